// File: rtl/l2_cache.sv
// l2_cache: set-associative, write-through, no-write-allocate L2 cache.
// Reads return a whole block to L1 (zero-wait on hit, after a memory block
// fetch on miss); writes always go straight to memory and also patch the
// cached copy when they hit. Victims are never written back.
module l2_cache #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 11,
   parameter int CACHE_SIZE = 512,
   parameter int BLOCK_SIZE = 32,
   parameter int NUM_WAYS   = 4,
   localparam int WORDS_PER_BLOCK = BLOCK_SIZE / (DATA_WIDTH / 8),
   localparam int BLOCK_W         = DATA_WIDTH * WORDS_PER_BLOCK
) (
   input  logic                  clk,
   input  logic                  rst_n,   // active-high synchronous reset despite the name
   input  logic [ADDR_WIDTH-1:0] l1_cache_addr,
   input  logic [DATA_WIDTH-1:0] l1_cache_data_in,
   input  logic                  l1_cache_read,
   input  logic                  l1_cache_write,
   output logic [BLOCK_W-1:0]    l1_block_data_out,
   output logic                  l1_block_valid,
   output logic                  l1_cache_ready,
   output logic                  l1_cache_hit,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_read,
   input  logic                  mem_ready,
   input  logic [BLOCK_W-1:0]    mem_data_block,
   output logic                  mem_write,
   output logic [DATA_WIDTH-1:0] mem_data_out
);

   localparam int NUM_SETS  = CACHE_SIZE / (BLOCK_SIZE * NUM_WAYS);
   localparam int OFFSET    = $clog2(BLOCK_SIZE);
   localparam int INDEX     = $clog2(NUM_SETS);
   localparam int TAG       = ADDR_WIDTH - OFFSET - INDEX;
   localparam int BYTE_BITS = $clog2(DATA_WIDTH / 8);
   localparam int WORD_BITS = $clog2(WORDS_PER_BLOCK);
   localparam int WAY_BITS  = $clog2(NUM_WAYS);

   typedef enum logic {ST_IDLE = 1'b0, ST_MISS_WAIT = 1'b1} state_t;

   // Cache storage: per set/way valid bit, tag, block and LRU age (0 = MRU).
   logic                r_valid [NUM_SETS][NUM_WAYS];
   logic [TAG-1:0]      r_tag   [NUM_SETS][NUM_WAYS];
   logic [WAY_BITS-1:0] r_age   [NUM_SETS][NUM_WAYS];
   logic [BLOCK_W-1:0]  r_data  [NUM_SETS][NUM_WAYS];

   state_t              r_state;
   logic [TAG-1:0]      r_miss_tag;
   logic [INDEX-1:0]    r_miss_set;

   logic [TAG-1:0]       w_tag;
   logic [INDEX-1:0]     w_set;
   logic [WORD_BITS-1:0] w_word;
   logic [NUM_WAYS-1:0]  w_way_hit;
   logic                 w_hit;
   logic [WAY_BITS-1:0]  w_hit_way;
   logic [WAY_BITS-1:0]  w_victim;
   logic [WAY_BITS-1:0]  w_lru_way;
   logic                 w_fill;
   logic                 w_write_hit;

   assign w_tag  = l1_cache_addr[ADDR_WIDTH-1 -: TAG];
   assign w_set  = l1_cache_addr[OFFSET +: INDEX];
   assign w_word = l1_cache_addr[BYTE_BITS +: WORD_BITS];

   // Parallel tag compare across all ways of the addressed set.
   for (genvar gi = 0; gi < NUM_WAYS; gi++) begin : g_tag_cmp
      assign w_way_hit[gi] = r_valid[w_set][gi] && (r_tag[w_set][gi] == w_tag);
   end

   assign w_hit = |w_way_hit;

   // Only one way can match, so the encoder's priority order is irrelevant.
   always_comb begin
      w_hit_way = '0;
      for (int j = NUM_WAYS - 1; j >= 0; j--) begin
         if (w_way_hit[j]) w_hit_way = WAY_BITS'(j);
      end
   end

   // Victim for the pending miss: lowest invalid way, else the oldest way.
   always_comb begin
      w_lru_way = '0;
      for (int j = 0; j < NUM_WAYS; j++) begin
         if (r_age[r_miss_set][j] == WAY_BITS'(NUM_WAYS - 1)) w_lru_way = WAY_BITS'(j);
      end
      w_victim = w_lru_way;
      for (int j = NUM_WAYS - 1; j >= 0; j--) begin
         if (!r_valid[r_miss_set][j]) w_victim = WAY_BITS'(j);
      end
   end

   assign w_fill      = (r_state == ST_MISS_WAIT) && mem_ready;
   assign w_write_hit = (r_state == ST_IDLE) && l1_cache_write && !l1_cache_read && w_hit;

   // New age of one way after an access; ways younger than the accessed one age by one.
   function automatic logic [WAY_BITS-1:0] f_next_age(
      input logic [WAY_BITS-1:0] age,
      input logic [WAY_BITS-1:0] acc_age,
      input logic                is_acc
   );
      if (is_acc)             return '0;
      else if (age < acc_age) return age + WAY_BITS'(1);
      else                    return age;
   endfunction

   // Block storage: whole-block fill on miss return, single-word patch on write hit.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         if (w_fill) begin
            r_data[r_miss_set][w_victim] <= mem_data_block;
         end else if (w_write_hit) begin
            r_data[w_set][w_hit_way][w_word*DATA_WIDTH +: DATA_WIDTH] <= l1_cache_data_in;
         end
      end
   end

   // Control FSM with registered outputs, plus valid/tag/LRU bookkeeping.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         r_state           <= ST_IDLE;
         r_miss_tag        <= '0;
         r_miss_set        <= '0;
         l1_block_data_out <= '0;
         l1_block_valid    <= 1'b0;
         l1_cache_ready    <= 1'b1;
         l1_cache_hit      <= 1'b0;
         mem_addr          <= '0;
         mem_read          <= 1'b0;
         mem_write         <= 1'b0;
         mem_data_out      <= '0;
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int j = 0; j < NUM_WAYS; j++) begin
               r_valid[s][j] <= 1'b0;
               r_tag[s][j]   <= '0;
               r_age[s][j]   <= WAY_BITS'(j);
            end
         end
      end else begin
         l1_block_valid <= 1'b0;
         l1_cache_hit   <= 1'b0;
         mem_write      <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (l1_cache_read) begin
                  if (w_hit) begin
                     l1_block_data_out <= r_data[w_set][w_hit_way];
                     l1_block_valid    <= 1'b1;
                     l1_cache_hit      <= 1'b1;
                     for (int j = 0; j < NUM_WAYS; j++) begin
                        r_age[w_set][j] <= f_next_age(r_age[w_set][j], r_age[w_set][w_hit_way],
                                                      WAY_BITS'(j) == w_hit_way);
                     end
                  end else begin
                     r_miss_tag     <= w_tag;
                     r_miss_set     <= w_set;
                     mem_addr       <= {l1_cache_addr[ADDR_WIDTH-1:OFFSET], {OFFSET{1'b0}}};
                     mem_read       <= 1'b1;
                     l1_cache_ready <= 1'b0;
                     r_state        <= ST_MISS_WAIT;
                  end
               end else if (l1_cache_write) begin
                  // Write-through: memory always sees the word, allocation never happens.
                  mem_write    <= 1'b1;
                  mem_addr     <= l1_cache_addr;
                  mem_data_out <= l1_cache_data_in;
                  if (w_hit) begin
                     l1_cache_hit <= 1'b1;
                     for (int j = 0; j < NUM_WAYS; j++) begin
                        r_age[w_set][j] <= f_next_age(r_age[w_set][j], r_age[w_set][w_hit_way],
                                                      WAY_BITS'(j) == w_hit_way);
                     end
                  end
               end
            end
            ST_MISS_WAIT: begin
               if (mem_ready) begin
                  r_valid[r_miss_set][w_victim] <= 1'b1;
                  r_tag[r_miss_set][w_victim]   <= r_miss_tag;
                  for (int j = 0; j < NUM_WAYS; j++) begin
                     r_age[r_miss_set][j] <= f_next_age(r_age[r_miss_set][j],
                                                        r_age[r_miss_set][w_victim],
                                                        WAY_BITS'(j) == w_victim);
                  end
                  l1_block_data_out <= mem_data_block;
                  l1_block_valid    <= 1'b1;
                  mem_read          <= 1'b0;
                  l1_cache_ready    <= 1'b1;
                  r_state           <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_l2_cache.sv
// tb_l2_cache: directed self-checking bench for l2_cache with a fixed-pattern
// memory (block b, word w = (b<<8)|w) answering one edge after mem_read.
module tb_l2_cache;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [10:0]  l1_cache_addr;
   logic [31:0]  l1_cache_data_in;
   logic         l1_cache_read;
   logic         l1_cache_write;
   logic [255:0] l1_block_data_out;
   logic         l1_block_valid;
   logic         l1_cache_ready;
   logic         l1_cache_hit;
   logic [10:0]  mem_addr;
   logic         mem_read;
   logic         mem_ready;
   logic [255:0] mem_data_block;
   logic         mem_write;
   logic [31:0]  mem_data_out;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   l2_cache dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .l1_cache_addr     (l1_cache_addr),
      .l1_cache_data_in  (l1_cache_data_in),
      .l1_cache_read     (l1_cache_read),
      .l1_cache_write    (l1_cache_write),
      .l1_block_data_out (l1_block_data_out),
      .l1_block_valid    (l1_block_valid),
      .l1_cache_ready    (l1_cache_ready),
      .l1_cache_hit      (l1_cache_hit),
      .mem_addr          (mem_addr),
      .mem_read          (mem_read),
      .mem_ready         (mem_ready),
      .mem_data_block    (mem_data_block),
      .mem_write         (mem_write),
      .mem_data_out      (mem_data_out)
   );

   function automatic logic [255:0] blk(input int b);
      logic [255:0] r;
      for (int w = 0; w < 8; w++) r[w*32 +: 32] = 32'((b << 8) | w);
      return r;
   endfunction

   // Issue one read; if the DUT misses, play a one-edge-latency memory.
   task automatic do_read(input logic [10:0] addr, output logic missed, output logic [10:0] maddr,
                          output logic ready_low, output logic early, output logic valid,
                          output logic hit, output logic [255:0] data, output logic mr_after);
      @(negedge clk);
      l1_cache_addr = addr;
      l1_cache_read = 1'b1;
      @(negedge clk);
      l1_cache_read = 1'b0;
      maddr = mem_addr;
      if (mem_read) begin
         missed    = 1'b1;
         ready_low = !l1_cache_ready;
         @(posedge clk);
         #1;
         mem_ready      = 1'b1;
         mem_data_block = blk(int'(mem_addr >> 5));
         @(negedge clk);
         early = l1_block_valid;
         @(negedge clk);
         mem_ready = 1'b0;
      end else begin
         missed    = 1'b0;
         ready_low = 1'b0;
         early     = 1'b0;
      end
      valid    = l1_block_valid;
      hit      = l1_cache_hit;
      data     = l1_block_data_out;
      mr_after = mem_read;
      $display("read  addr=%0d missed=%0b mem_addr=%0d valid=%0b hit=%0b w0=%h", addr, missed,
               maddr, valid, hit, data[31:0]);
   endtask

   // Issue one write and capture the memory-side strobe and the following cycle.
   task automatic do_write(input logic [10:0] addr, input logic [31:0] d, output logic mw,
                           output logic [10:0] ma, output logic [31:0] md, output logic hit,
                           output logic rdy, output logic mw_next);
      @(negedge clk);
      l1_cache_addr    = addr;
      l1_cache_data_in = d;
      l1_cache_write   = 1'b1;
      @(negedge clk);
      l1_cache_write = 1'b0;
      mw  = mem_write;
      ma  = mem_addr;
      md  = mem_data_out;
      hit = l1_cache_hit;
      rdy = l1_cache_ready;
      @(negedge clk);
      mw_next = mem_write;
      $display("write addr=%0d data=%h mem_write=%0b mem_addr=%0d hit=%0b", addr, d, mw, ma, hit);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      $display("reset released");
      n_checks++; if (l1_cache_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", l1_cache_ready); end
      n_checks++; if (l1_block_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", l1_block_valid); end
      n_checks++; if (l1_cache_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit got %b want 0", l1_cache_hit); end
      n_checks++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin n_fail++; $display("FAIL reset_mem_strobes got rd=%b wr=%b want 0 0", mem_read, mem_write); end
      n_checks++; if (mem_addr !== 11'd0 || mem_data_out !== 32'd0) begin n_fail++; $display("FAIL reset_mem_bus got addr=%h data=%h want 0 0", mem_addr, mem_data_out); end
      n_checks++; if (l1_block_data_out !== 256'd0) begin n_fail++; $display("FAIL reset_block_data got %h want 0", l1_block_data_out); end
   endtask

   task automatic test_cold_miss();
      logic m, rl, e, v, h, mra; logic [10:0] ma; logic [255:0] d;
      do_read(11'd108, m, ma, rl, e, v, h, d, mra);
      n_checks++; if (m !== 1'b1) begin n_fail++; $display("FAIL cold_mem_read got %b want 1", m); end
      n_checks++; if (ma !== 11'd96) begin n_fail++; $display("FAIL cold_mem_addr got %0d want 96", ma); end
      n_checks++; if (rl !== 1'b1) begin n_fail++; $display("FAIL cold_ready_low got %b want 1", rl); end
      n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL cold_early_valid got %b want 0", e); end
      n_checks++; if (v !== 1'b1 || h !== 1'b0) begin n_fail++; $display("FAIL cold_valid_hit got v=%b h=%b want 1 0", v, h); end
      n_checks++; if (d !== blk(3)) begin n_fail++; $display("FAIL cold_data got %h want %h", d, blk(3)); end
      n_checks++; if (mra !== 1'b0 || l1_cache_ready !== 1'b1) begin n_fail++; $display("FAIL cold_done got rd=%b rdy=%b want 0 1", mra, l1_cache_ready); end
   endtask

   task automatic test_read_hit();
      logic m, rl, e, v, h, mra; logic [10:0] ma; logic [255:0] d;
      do_read(11'd116, m, ma, rl, e, v, h, d, mra);
      n_checks++; if (m !== 1'b0) begin n_fail++; $display("FAIL hit_no_mem_read got %b want 0", m); end
      n_checks++; if (v !== 1'b1 || h !== 1'b1) begin n_fail++; $display("FAIL hit_valid_hit got v=%b h=%b want 1 1", v, h); end
      n_checks++; if (d !== blk(3)) begin n_fail++; $display("FAIL hit_data got %h want %h", d, blk(3)); end
      @(negedge clk);
      n_checks++; if (l1_block_valid !== 1'b0 || l1_cache_hit !== 1'b0) begin n_fail++; $display("FAIL hit_pulse_width got v=%b h=%b want 0 0", l1_block_valid, l1_cache_hit); end
      n_checks++; if (l1_block_data_out !== blk(3)) begin n_fail++; $display("FAIL hit_data_hold got %h want %h", l1_block_data_out, blk(3)); end
   endtask

   task automatic test_write_hit();
      logic mw, h, r, mwn; logic [10:0] ma; logic [31:0] md;
      do_write(11'd104, 32'hDEADBEEF, mw, ma, md, h, r, mwn);
      n_checks++; if (mw !== 1'b1 || mwn !== 1'b0) begin n_fail++; $display("FAIL wh_strobe got %b,%b want 1,0", mw, mwn); end
      n_checks++; if (ma !== 11'd104 || md !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wh_mem_bus got addr=%0d data=%h want 104 deadbeef", ma, md); end
      n_checks++; if (h !== 1'b1 || r !== 1'b1) begin n_fail++; $display("FAIL wh_hit_ready got h=%b r=%b want 1 1", h, r); end
   endtask

   task automatic test_write_miss();
      logic mw, h, r, mwn, m, rl, e, v, hh, mra; logic [10:0] ma; logic [31:0] md; logic [255:0] d;
      do_write(11'd600, 32'h12345678, mw, ma, md, h, r, mwn);
      n_checks++; if (mw !== 1'b1 || ma !== 11'd600 || md !== 32'h12345678) begin n_fail++; $display("FAIL wm_mem_bus got wr=%b addr=%0d data=%h want 1 600 12345678", mw, ma, md); end
      n_checks++; if (h !== 1'b0) begin n_fail++; $display("FAIL wm_hit got %b want 0", h); end
      do_read(11'd600, m, ma, rl, e, v, hh, d, mra);
      n_checks++; if (m !== 1'b1 || ma !== 11'd576) begin n_fail++; $display("FAIL wm_no_alloc got miss=%b addr=%0d want 1 576", m, ma); end
      n_checks++; if (d !== blk(18) || hh !== 1'b0) begin n_fail++; $display("FAIL wm_fill got h=%b d=%h want 0 %h", hh, d, blk(18)); end
   endtask

   task automatic test_lru_evict();
      logic m, rl, e, v, h, mra; logic [10:0] ma; logic [255:0] d;
      logic [10:0] addrs [5];
      addrs = '{11'd0, 11'd128, 11'd256, 11'd384, 11'd512};
      for (int i = 0; i < 5; i++) begin
         do_read(addrs[i], m, ma, rl, e, v, h, d, mra);
         n_checks++; if (m !== 1'b1 || d !== blk(i * 4)) begin n_fail++; $display("FAIL lru_fill%0d got miss=%b d=%h want 1 %h", i, m, d, blk(i * 4)); end
      end
      do_read(11'd0, m, ma, rl, e, v, h, d, mra);
      n_checks++; if (m !== 1'b1 || ma !== 11'd0) begin n_fail++; $display("FAIL lru_evicted0 got miss=%b addr=%0d want 1 0", m, ma); end
      do_read(11'd256, m, ma, rl, e, v, h, d, mra);
      n_checks++; if (m !== 1'b0 || h !== 1'b1 || d !== blk(8)) begin n_fail++; $display("FAIL lru_keep8 got miss=%b h=%b d=%h want 0 1 %h", m, h, d, blk(8)); end
      do_read(11'd128, m, ma, rl, e, v, h, d, mra);
      n_checks++; if (m !== 1'b1) begin n_fail++; $display("FAIL lru_evicted4 got miss=%b want 1", m); end
   endtask

   task automatic test_read_write_both();
      @(negedge clk);
      l1_cache_addr    = 11'd116;
      l1_cache_data_in = 32'hFFFFFFFF;
      l1_cache_read    = 1'b1;
      l1_cache_write   = 1'b1;
      @(negedge clk);
      l1_cache_read  = 1'b0;
      l1_cache_write = 1'b0;
      $display("read+write addr=116 valid=%0b hit=%0b mem_write=%0b", l1_block_valid, l1_cache_hit, mem_write);
      n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL both_write_dropped got %b want 0", mem_write); end
      n_checks++; if (l1_block_valid !== 1'b1 || l1_cache_hit !== 1'b1) begin n_fail++; $display("FAIL both_read_wins got v=%b h=%b want 1 1", l1_block_valid, l1_cache_hit); end
   endtask

   task automatic test_ignored_inputs();
      logic m, rl, e, v, h, mra; logic [10:0] ma; logic [255:0] d;
      @(negedge clk);
      l1_cache_addr = 11'd800;
      l1_cache_read = 1'b1;
      @(negedge clk);
      l1_cache_read    = 1'b0;
      l1_cache_addr    = 11'd104;
      l1_cache_data_in = 32'h00001234;
      l1_cache_write   = 1'b1;
      @(negedge clk);
      l1_cache_write = 1'b0;
      $display("write during miss: mem_write=%0b mem_read=%0b", mem_write, mem_read);
      n_checks++; if (mem_write !== 1'b0 || mem_read !== 1'b1) begin n_fail++; $display("FAIL busy_ignore got wr=%b rd=%b want 0 1", mem_write, mem_read); end
      mem_ready      = 1'b1;
      mem_data_block = blk(25);
      @(negedge clk);
      mem_ready = 1'b0;
      n_checks++; if (l1_block_valid !== 1'b1 || l1_block_data_out !== blk(25)) begin n_fail++; $display("FAIL busy_fill got v=%b d=%h want 1 %h", l1_block_valid, l1_block_data_out, blk(25)); end
      mem_ready      = 1'b1;
      mem_data_block = blk(99);
      @(negedge clk);
      mem_ready = 1'b0;
      $display("stray mem_ready in idle: valid=%0b", l1_block_valid);
      n_checks++; if (l1_block_valid !== 1'b0 || l1_cache_ready !== 1'b1) begin n_fail++; $display("FAIL stray_ready got v=%b rdy=%b want 0 1", l1_block_valid, l1_cache_ready); end
      do_read(11'd800, m, ma, rl, e, v, h, d, mra);
      n_checks++; if (m !== 1'b0 || d !== blk(25)) begin n_fail++; $display("FAIL stray_no_change got miss=%b d=%h want 0 %h", m, d, blk(25)); end
   endtask

   task automatic test_back_to_back();
      logic m, rl, e, v, h, mra; logic [10:0] ma; logic [255:0] d; logic [255:0] exp_blk;
      @(negedge clk);
      l1_cache_addr    = 11'd100;
      l1_cache_data_in = 32'hAAAA0001;
      l1_cache_write   = 1'b1;
      @(negedge clk);
      l1_cache_addr    = 11'd120;
      l1_cache_data_in = 32'hBBBB0006;
      n_checks++; if (mem_write !== 1'b1 || mem_addr !== 11'd100 || mem_data_out !== 32'hAAAA0001 || l1_cache_hit !== 1'b1) begin n_fail++; $display("FAIL b2b_first got wr=%b addr=%0d data=%h h=%b want 1 100 aaaa0001 1", mem_write, mem_addr, mem_data_out, l1_cache_hit); end
      @(negedge clk);
      l1_cache_write = 1'b0;
      $display("write burst addr=120 mem_write=%0b mem_addr=%0d", mem_write, mem_addr);
      n_checks++; if (mem_write !== 1'b1 || mem_addr !== 11'd120 || mem_data_out !== 32'hBBBB0006) begin n_fail++; $display("FAIL b2b_second got wr=%b addr=%0d data=%h want 1 120 bbbb0006", mem_write, mem_addr, mem_data_out); end
      @(negedge clk);
      n_checks++; if (mem_write !== 1'b0) begin n_fail++; $display("FAIL b2b_end got %b want 0", mem_write); end
      exp_blk = blk(3);
      exp_blk[2*32 +: 32] = 32'hDEADBEEF;
      exp_blk[1*32 +: 32] = 32'hAAAA0001;
      exp_blk[6*32 +: 32] = 32'hBBBB0006;
      do_read(11'd96, m, ma, rl, e, v, h, d, mra);
      n_checks++; if (m !== 1'b0 || h !== 1'b1) begin n_fail++; $display("FAIL b2b_read_hit got miss=%b h=%b want 0 1", m, h); end
      n_checks++; if (d[2*32 +: 32] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wh_word2 got %h want deadbeef", d[2*32 +: 32]); end
      n_checks++; if (d !== exp_blk) begin n_fail++; $display("FAIL b2b_block got %h want %h", d, exp_blk); end
   endtask

   task automatic test_reset_mid_miss();
      logic m, rl, e, v, h, mra; logic [10:0] ma; logic [255:0] d;
      @(negedge clk);
      l1_cache_addr = 11'd700;
      l1_cache_read = 1'b1;
      @(negedge clk);
      l1_cache_read = 1'b0;
      n_checks++; if (mem_read !== 1'b1) begin n_fail++; $display("FAIL mid_miss_start got %b want 1", mem_read); end
      rst_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      $display("reset during miss: mem_read=%0b ready=%0b", mem_read, l1_cache_ready);
      n_checks++; if (mem_read !== 1'b0 || l1_cache_ready !== 1'b1 || l1_block_data_out !== 256'd0) begin n_fail++; $display("FAIL mid_miss_reset got rd=%b rdy=%b d=%h want 0 1 0", mem_read, l1_cache_ready, l1_block_data_out); end
      do_read(11'd116, m, ma, rl, e, v, h, d, mra);
      n_checks++; if (m !== 1'b1 || d !== blk(3)) begin n_fail++; $display("FAIL mid_miss_invalidated got miss=%b d=%h want 1 %h", m, d, blk(3)); end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n            = 1'b1;
      l1_cache_addr    = '0;
      l1_cache_data_in = '0;
      l1_cache_read    = 1'b0;
      l1_cache_write   = 1'b0;
      mem_ready        = 1'b0;
      mem_data_block   = '0;
      test_reset();
      test_cold_miss();
      test_read_hit();
      test_write_hit();
      test_write_miss();
      test_lru_evict();
      test_read_write_both();
      test_ignored_inputs();
      test_back_to_back();
      test_reset_mid_miss();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
